// File: rtl/pheap_leq.sv
// pheap_leq: one level of a pipelined heap; takes INSERT/REMOVE tokens, updates its node, forwards to a child.
// Define PHEAP_MAX_EN for max-heap ordering (min-heap otherwise).
module pheap_leq #(
   parameter int LEVEL = 2,
   parameter int DEPTH = 4,
   parameter int KEY_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             phase,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [LEVEL-2:0] in_idx,
   input  logic [KEY_W-1:0] in_key,
   output logic             out_valid,
   output logic [1:0]       out_op,
   output logic [LEVEL-1:0] out_idx,
   output logic [KEY_W-1:0] out_key,
   output logic             topActive,
   output logic             wenTop,
   output logic [LEVEL-2:0] raddrTop,
   output logic [LEVEL-2:0] wraddrTop,
   output logic [KEY_W:0]   aTop,
   input  logic [KEY_W:0]   yTop,
   output logic [LEVEL-1:0] raddrBot,
   input  logic [KEY_W:0]   yBotL,
   input  logic [KEY_W:0]   yBotR,
   output logic             err_ovf,
   output logic             err_unf
);
   localparam int AW = LEVEL - 1;
   localparam int NN = 1 << AW;
   localparam int CW = DEPTH - LEVEL + 1;
   localparam bit LEAF = LEVEL == DEPTH;
   localparam logic [CW-1:0] VR = CW'((1 << (DEPTH - LEVEL)) - 1);
   localparam logic [1:0] OP_INS = 2'b01;
   localparam logic [1:0] OP_REM = 2'b10;
   typedef enum logic [2:0] {INIT, IDLE, RD, WR, CL1, CL2, CL3} state_e;
   state_e st_q;
   logic act;
   logic [AW-1:0] cnt_q, idx_q;
   logic [1:0] op_q, oop_q;
   logic [KEY_W-1:0] key_q, okey_q;
   logic [LEVEL-1:0] oidx_q;
   logic wen_q, fwd_q, ov_q, ovf_q, unf_q;
   logic [KEY_W:0] wdata_q;
   logic [CW-1:0] vac_l_q [NN];
   logic [CW-1:0] vac_r_q [NN];
   logic [CW-1:0] vl, vr;
   logic nv, lv, rv, swap;
   logic [KEY_W-1:0] nk, lk, rk;
   logic side_d, fwd_d, wen_d, ovf_d, unf_d;
   logic [KEY_W:0] wdata_d;
   logic [KEY_W-1:0] fkey_d;
   function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
`ifdef PHEAP_MAX_EN
      return a > b;
`else
      return a < b;
`endif
   endfunction
   assign act = phase == 1'(LEVEL % 2);
   assign {nv, nk} = yTop;
   assign {lv, lk} = LEAF ? '0 : yBotL;
   assign {rv, rk} = LEAF ? '0 : yBotR;
   assign vl = vac_l_q[idx_q];
   assign vr = vac_r_q[idx_q];
   assign swap = better(key_q, nk);
   always_comb begin
      side_d = (op_q == OP_INS) ? vl == '0 : !lv || (rv && better(rk, lk));
      fwd_d = !LEAF && nv && ((op_q == OP_INS) ? (vl != '0 || vr != '0) : (op_q == OP_REM) && (lv || rv));
      ovf_d = (op_q == OP_INS) && nv && !fwd_d;
      unf_d = (op_q == OP_REM) && !nv;
      wen_d = (op_q == OP_INS) ? (!nv || swap) : (op_q == OP_REM) && nv;
      wdata_d = (op_q == OP_INS) ? {1'b1, key_q} : fwd_d ? {1'b1, side_d ? rk : lk} : '0;
      fkey_d = (op_q == OP_INS && swap) ? nk : key_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q <= INIT;
         cnt_q <= '0;
         idx_q <= '0;
         op_q <= '0;
         key_q <= '0;
         wen_q <= 1'b0;
         wdata_q <= '0;
         fwd_q <= 1'b0;
         ov_q <= 1'b0;
         oop_q <= '0;
         oidx_q <= '0;
         okey_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         for (int i = 0; i < NN; i++) begin
            vac_l_q[i] <= VR;
            vac_r_q[i] <= VR;
         end
      end else begin
         wen_q <= 1'b0;
         ov_q <= 1'b0;
         case (st_q)
            INIT: if (act) begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == AW'(NN - 1)) st_q <= IDLE;
            end
            IDLE: if (act && in_valid) begin
               st_q <= RD;
               op_q <= in_op;
               idx_q <= in_idx;
               key_q <= in_key;
            end
            RD: begin
               st_q <= WR;
               wen_q <= wen_d;
               wdata_q <= wdata_d;
               fwd_q <= fwd_d;
               oop_q <= op_q;
               oidx_q <= {idx_q, side_d};
               okey_q <= fkey_d;
               ovf_q <= ovf_q | ovf_d;
               unf_q <= unf_q | unf_d;
               // inserts consume a slot below, removes free one; both saturate
               if (fwd_d && !side_d) vac_l_q[idx_q] <= (op_q == OP_INS) ? vl - CW'(vl != '0) : vl + CW'(vl != VR);
               if (fwd_d && side_d) vac_r_q[idx_q] <= (op_q == OP_INS) ? vr - CW'(vr != '0) : vr + CW'(vr != VR);
            end
            WR: begin
               st_q <= CL1;
               ov_q <= fwd_q;
            end
            CL1: st_q <= CL2;
            CL2: st_q <= CL3;
            CL3: st_q <= IDLE;
            default: st_q <= INIT;
         endcase
      end
   end
   assign topActive = act;
   assign in_ready = st_q == IDLE && act;
   assign raddrTop = st_q == IDLE ? in_idx : idx_q;
   assign raddrBot = LEAF ? '0 : {raddrTop, 1'b0};
   // gated by rst_n so a reset landing on the write cycle suppresses the write
   assign wenTop = rst_n && (wen_q || (st_q == INIT && act));
   assign wraddrTop = st_q == INIT ? cnt_q : idx_q;
   assign aTop = st_q == INIT ? '0 : wdata_q;
   assign out_valid = ov_q;
   assign out_op = oop_q;
   assign out_idx = oidx_q;
   assign out_key = okey_q;
   assign err_ovf = ovf_q;
   assign err_unf = unf_q;
endmodule
